// File: rtl/stream_req_arbiter.sv
// Round-robin arbiter sharing one registered request port among nstrms streams.
// Credit limiting, completion accounting and o_err are built only with `STREAM_REQ_ARB_CREDIT_EN.
module stream_req_arbiter #(
   parameter int unsigned nstrms       = 64,
   parameter int unsigned nstrms_width = $clog2(nstrms),
   parameter int unsigned addr_width   = 64,
   parameter int unsigned max_out      = 4,
   parameter int unsigned cnt_width    = $clog2(max_out + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [nstrms-1:0]            i_req_v,
   output logic [nstrms-1:0]            i_req_r,
   input  logic [nstrms*addr_width-1:0] i_req_ea,
   output logic                         o_req_v,
   input  logic                         o_req_r,
   output logic [nstrms_width-1:0]      o_req_sid,
   output logic [addr_width-1:0]        o_req_ea,
   input  logic                         i_cpl_v,
   output logic                         i_cpl_r,
   input  logic [nstrms_width-1:0]      i_cpl_sid,
   output logic                         o_err
);

   logic                    out_v;
   logic [nstrms_width-1:0] out_sid;
   logic [addr_width-1:0]   out_ea;
   logic [nstrms_width-1:0] rr_ptr;
   logic [nstrms_width-1:0] grant_sid;
   logic [nstrms-1:0]       elig;
   logic [nstrms-1:0]       elig_hi;
   logic                    grant_any;
   logic                    loadable;
   logic                    fire;

   assign loadable = ~out_v | o_req_r;
   assign fire     = grant_any & loadable & reset;

   // Search upward from rr_ptr: prefer eligible streams at/above the pointer, else wrap to the lowest.
   always_comb begin
      elig_hi   = '0;
      grant_any = 1'b0;
      grant_sid = '0;
      for (int unsigned s = 0; s < nstrms; s++)
         elig_hi[s] = elig[s] && (s >= 32'(rr_ptr));
      for (int unsigned s = 0; s < nstrms; s++) begin
         if (elig_hi[s] && !grant_any) begin
            grant_any = 1'b1;
            grant_sid = nstrms_width'(s);
         end
      end
      for (int unsigned s = 0; s < nstrms; s++) begin
         if (elig[s] && !grant_any) begin
            grant_any = 1'b1;
            grant_sid = nstrms_width'(s);
         end
      end
   end

   always_comb begin
      i_req_r = '0;
      if (fire)
         i_req_r[grant_sid] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_v   <= 1'b0;
         out_sid <= '0;
         out_ea  <= '0;
         rr_ptr  <= '0;
      end else if (loadable) begin
         out_v <= grant_any;
         if (grant_any) begin
            out_sid <= grant_sid;
            out_ea  <= i_req_ea[32'(grant_sid)*addr_width +: addr_width];
            rr_ptr  <= (grant_sid == nstrms_width'(nstrms - 1)) ? '0
                                                                : grant_sid + nstrms_width'(1);
         end
      end
   end

   assign o_req_v   = out_v;
   assign o_req_sid = out_sid;
   assign o_req_ea  = out_ea;

`ifdef STREAM_REQ_ARB_CREDIT_EN
   logic [cnt_width-1:0] cnt [nstrms];
   logic [nstrms-1:0]    cnt_inc;
   logic [nstrms-1:0]    cnt_dec;
   logic                 cpl_bad;
   logic                 err;

   always_comb begin
      elig    = '0;
      cnt_inc = '0;
      cnt_dec = '0;
      cpl_bad = i_cpl_v && (32'(i_cpl_sid) >= nstrms);
      for (int unsigned s = 0; s < nstrms; s++) begin
         elig[s]    = i_req_v[s] && (cnt[s] < cnt_width'(max_out));
         cnt_inc[s] = fire && (grant_sid == nstrms_width'(s));
         if (i_cpl_v && (i_cpl_sid == nstrms_width'(s))) begin
            if (cnt[s] == '0)
               cpl_bad = 1'b1;
            else
               cnt_dec[s] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
         for (int unsigned s = 0; s < nstrms; s++)
            cnt[s] <= '0;
      end else begin
         if (cpl_bad)
            err <= 1'b1;
         for (int unsigned s = 0; s < nstrms; s++) begin
            if (cnt_inc[s] && !cnt_dec[s])
               cnt[s] <= cnt[s] + cnt_width'(1);
            else if (cnt_dec[s] && !cnt_inc[s])
               cnt[s] <= cnt[s] - cnt_width'(1);
         end
      end
   end

   assign i_cpl_r = reset;
   assign o_err   = err;
`else
   logic unused_cpl;

   assign elig       = i_req_v;
   assign i_cpl_r    = 1'b1;
   assign o_err      = 1'b0;
   assign unused_cpl = ^{i_cpl_v, i_cpl_sid};
`endif

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Directed bench for stream_req_arbiter (4 streams, max_out 2); expectations follow
// whichever way STREAM_REQ_ARB_CREDIT_EN is set for the build.
module tb_stream_req_arbiter;
   localparam int unsigned NS = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned SW = 2;

`ifdef STREAM_REQ_ARB_CREDIT_EN
   localparam bit CR = 1'b1;
`else
   localparam bit CR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NS-1:0]    i_req_v;
   logic [NS-1:0]    i_req_r;
   logic [NS*AW-1:0] i_req_ea;
   logic             o_req_v;
   logic             o_req_r;
   logic [SW-1:0]    o_req_sid;
   logic [AW-1:0]    o_req_ea;
   logic             i_cpl_v;
   logic             i_cpl_r;
   logic [SW-1:0]    i_cpl_sid;
   logic             o_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [AW-1:0] ea_tab [NS];

   stream_req_arbiter #(
      .nstrms    (NS),
      .addr_width(AW),
      .max_out   (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req_v  (i_req_v),
      .i_req_r  (i_req_r),
      .i_req_ea (i_req_ea),
      .o_req_v  (o_req_v),
      .o_req_r  (o_req_r),
      .o_req_sid(o_req_sid),
      .o_req_ea (o_req_ea),
      .i_cpl_v  (i_cpl_v),
      .i_cpl_r  (i_cpl_r),
      .i_cpl_sid(i_cpl_sid),
      .o_err    (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       cv;
      logic [1:0] cs;
      logic [3:0] xr;
      logic       xv;
      logic [1:0] xs;
      logic       xe;
   } vec_t;

   vec_t tab [$];

   function automatic vec_t mk(input logic [3:0] req, input logic cv, input logic [1:0] cs,
                               input logic [3:0] xr, input logic xv, input logic [1:0] xs,
                               input logic xe);
      vec_t v;
      v.req = req; v.cv = cv; v.cs = cs; v.xr = xr; v.xv = xv; v.xs = xs; v.xe = xe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ea();
      for (int s = 0; s < NS; s++)
         i_req_ea[s*AW +: AW] = ea_tab[s];
   endtask

   task automatic run_row(input vec_t r, input int idx);
      i_req_v   = r.req;
      i_cpl_v   = r.cv;
      i_cpl_sid = r.cs;
      o_req_r   = 1'b1;
      #3;
      chk($sformatf("row%0d i_req_r", idx), 32'(i_req_r), 32'(r.xr));
      chk($sformatf("row%0d o_req_v", idx), 32'(o_req_v), 32'(r.xv));
      if (r.xv) begin
         chk($sformatf("row%0d o_req_sid", idx), 32'(o_req_sid), 32'(r.xs));
         chk($sformatf("row%0d o_req_ea", idx), 32'(o_req_ea), 32'(ea_tab[r.xs]));
      end
      chk($sformatf("row%0d o_err", idx), 32'(o_err), 32'(r.xe));
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;

      ea_tab[0] = 16'h0A00;
      ea_tab[1] = 16'h1000;
      ea_tab[2] = 16'h2B00;
      ea_tab[3] = 16'h3C00;
      set_ea();
      i_req_v   = 4'b1111;
      o_req_r   = 1'b1;
      i_cpl_v   = 1'b0;
      i_cpl_sid = '0;

      // Fairness, completions returned the cycle after each grant (first grant happens at release)
      tab.push_back(mk(4'b1111, 1, 2'd0, 4'b0010, 1, 2'd0, 0));
      tab.push_back(mk(4'b1111, 1, 2'd1, 4'b0100, 1, 2'd1, 0));
      tab.push_back(mk(4'b1111, 1, 2'd2, 4'b1000, 1, 2'd2, 0));
      tab.push_back(mk(4'b1111, 1, 2'd3, 4'b0001, 1, 2'd3, 0));
      tab.push_back(mk(4'b1111, 1, 2'd0, 4'b0010, 1, 2'd0, 0));
      tab.push_back(mk(4'b0000, 1, 2'd1, 4'b0000, 1, 2'd1, 0));
      tab.push_back(mk(4'b0000, 0, 2'd0, 4'b0000, 0, 2'd0, 0));
      // Credit limit on stream 2, then one completion
      tab.push_back(mk(4'b0100, 0, 2'd0, 4'b0100, 0, 2'd0, 0));
      tab.push_back(mk(4'b0100, 0, 2'd0, 4'b0100, 1, 2'd2, 0));
      tab.push_back(mk(4'b0100, 0, 2'd0, CR ? 4'b0000 : 4'b0100, 1, 2'd2, 0));
      tab.push_back(mk(4'b0100, 0, 2'd0, CR ? 4'b0000 : 4'b0100, !CR, 2'd2, 0));
      tab.push_back(mk(4'b0100, 0, 2'd0, CR ? 4'b0000 : 4'b0100, !CR, 2'd2, 0));
      tab.push_back(mk(4'b0100, 1, 2'd2, CR ? 4'b0000 : 4'b0100, !CR, 2'd2, 0));
      tab.push_back(mk(4'b0100, 0, 2'd0, 4'b0100, !CR, 2'd2, 0));
      tab.push_back(mk(4'b0000, 0, 2'd0, 4'b0000, 1, 2'd2, 0));
      tab.push_back(mk(4'b0000, 1, 2'd2, 4'b0000, 0, 2'd0, 0));
      tab.push_back(mk(4'b0000, 1, 2'd2, 4'b0000, 0, 2'd0, 0));
      // Grant and completion on stream 3 together, then probe the remaining credit
      tab.push_back(mk(4'b1000, 0, 2'd0, 4'b1000, 0, 2'd0, 0));
      tab.push_back(mk(4'b1000, 1, 2'd3, 4'b1000, 1, 2'd3, 0));
      tab.push_back(mk(4'b0000, 0, 2'd0, 4'b0000, 1, 2'd3, 0));
      tab.push_back(mk(4'b1000, 0, 2'd0, 4'b1000, 0, 2'd0, 0));
      tab.push_back(mk(4'b1000, 0, 2'd0, CR ? 4'b0000 : 4'b1000, 1, 2'd3, 0));
      tab.push_back(mk(4'b0000, 1, 2'd3, 4'b0000, !CR, 2'd3, 0));
      tab.push_back(mk(4'b0000, 1, 2'd3, 4'b0000, 0, 2'd0, 0));
      // Completion for idle stream 1: sticky error, count must stay at zero
      tab.push_back(mk(4'b0000, 1, 2'd1, 4'b0000, 0, 2'd0, 0));
      tab.push_back(mk(4'b0000, 0, 2'd0, 4'b0000, 0, 2'd0, CR));
      tab.push_back(mk(4'b0010, 0, 2'd0, 4'b0010, 0, 2'd0, CR));
      tab.push_back(mk(4'b0010, 0, 2'd0, 4'b0010, 1, 2'd1, CR));
      tab.push_back(mk(4'b0010, 0, 2'd0, CR ? 4'b0000 : 4'b0010, 1, 2'd1, CR));
      tab.push_back(mk(4'b0000, 0, 2'd0, 4'b0000, !CR, 2'd1, CR));
      tab.push_back(mk(4'b0000, 1, 2'd1, 4'b0000, 0, 2'd0, CR));
      tab.push_back(mk(4'b0000, 1, 2'd1, 4'b0000, 0, 2'd0, CR));

      // Reset held with all streams requesting
      next_cycle();
      next_cycle();
      chk("rst o_req_v", 32'(o_req_v), 0);
      chk("rst i_req_r", 32'(i_req_r), 0);
      chk("rst o_req_sid", 32'(o_req_sid), 0);
      chk("rst o_req_ea", 32'(o_req_ea), 0);
      chk("rst o_err", 32'(o_err), 0);
      chk("rst i_cpl_r", 32'(i_cpl_r), CR ? 0 : 1);

      next_cycle();
      reset = 1'b1;
      #3;
      chk("rel i_req_r", 32'(i_req_r), 32'(4'b0001));
      chk("rel o_req_v", 32'(o_req_v), 0);
      chk("rel i_cpl_r", 32'(i_cpl_r), 1);
      next_cycle();

      foreach (tab[i])
         run_row(tab[i], i);

      // Backpressure: stream 1 held in the output stage for several stalled cycles
      grants    = 0;
      i_req_v   = 4'b0010;
      i_cpl_v   = 1'b0;
      o_req_r   = 1'b0;
      #3;
      chk("bp0 i_req_r", 32'(i_req_r), 32'(4'b0010));
      chk("bp0 o_req_v", 32'(o_req_v), 0);
      if (i_req_r[1]) grants++;
      next_cycle();
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) i_req_ea[1*AW +: AW] = 16'h5555;
         #3;
         chk($sformatf("bp%0d o_req_v", k), 32'(o_req_v), 1);
         chk($sformatf("bp%0d o_req_sid", k), 32'(o_req_sid), 1);
         chk($sformatf("bp%0d o_req_ea", k), 32'(o_req_ea), 32'h1000);
         if (i_req_r[1]) grants++;
         next_cycle();
      end
      chk("bp grant count", 32'(grants), 1);
      set_ea();
      i_req_v = 4'b0000;
      o_req_r = 1'b1;
      #3;
      chk("bp6 o_req_v", 32'(o_req_v), 1);
      chk("bp6 o_req_ea", 32'(o_req_ea), 32'h1000);
      next_cycle();
      i_cpl_v   = 1'b1;
      i_cpl_sid = 2'd1;
      #3;
      chk("bp7 o_req_v", 32'(o_req_v), 0);
      next_cycle();
      i_cpl_v = 1'b0;

      // Asynchronous reset mid-operation drops the pending request and the pointer
      i_req_v = 4'b0001;
      o_req_r = 1'b0;
      #3;
      chk("ar0 i_req_r", 32'(i_req_r), 32'(4'b0001));
      next_cycle();
      chk("ar1 o_req_v", 32'(o_req_v), 1);
      reset = 1'b0;
      #1;
      chk("ar o_req_v", 32'(o_req_v), 0);
      chk("ar o_err", 32'(o_err), 0);
      chk("ar i_req_r", 32'(i_req_r), 0);
      chk("ar i_cpl_r", 32'(i_cpl_r), CR ? 0 : 1);
      next_cycle();
      reset   = 1'b1;
      i_req_v = 4'b1111;
      o_req_r = 1'b1;
      #3;
      chk("ar rel i_req_r", 32'(i_req_r), 32'(4'b0001));
      next_cycle();
      chk("ar rel o_req_v", 32'(o_req_v), 1);
      chk("ar rel o_req_sid", 32'(o_req_sid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_req_arbiter.md
# stream_req_arbiter

Round-robin arbiter that shares the single tagged memory-request port between `nstrms` stream requesters. It sits in front of the tag interface's request input. It grants one stream per cycle into a registered output stage and enforces a per-stream limit on outstanding requests. The limit uses credit counters that are returned by the response path's stream ID.

## Interface
- `nstrms`, 64, number of requesting streams
- `nstrms_width`, `$clog2(nstrms)`, stream ID width
- `addr_width`, 64, effective-address width
- `max_out`, 4, maximum outstanding requests per stream (1..15)
- `cnt_width`, `$clog2(max_out+1)`, credit counter width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  reset, asynchronous active-low (0 = reset asserted)
- `i_req_v`  in  nstrms  per-stream request valid
- `i_req_r`  out  nstrms  per-stream request ready; one-hot or zero
- `i_req_ea`  in  nstrms*addr_width  per-stream address; stream s occupies bits [s*addr_width +: addr_width]
- `o_req_v`  out  1  granted request valid
- `o_req_r`  in  1  downstream ready
- `o_req_sid`  out  nstrms_width  granted stream ID
- `o_req_ea`  out  addr_width  granted address
- `i_cpl_v`  in  1  completion (response accepted downstream) valid
- `i_cpl_r`  out  1  completion ready; constant 1 when out of reset
- `i_cpl_sid`  in  nstrms_width  stream the completion belongs to
- `o_err`  out  1  sticky error: a completion arrived for a stream with zero outstanding requests

## Operation
- Output stage: a single register holding `{v, sid, ea}`. It is loadable when empty or when `o_req_v & o_req_r` in the same cycle.
- Eligibility: stream s is eligible when `i_req_v[s]` is high and `cnt[s] < max_out`.
- Grant: when loadable, select the first eligible stream searching upward from `rr_ptr`, wrapping modulo `nstrms`; `nstrms` need not be a power of two.
- On grant of stream g:
  - `i_req_r[g]=1` combinationally in the same cycle.
  - Load the output register with g and `i_req_ea[g]`.
  - Next `rr_ptr = (g+1) mod nstrms`.
  - `cnt[g]` increments.
- With no eligible stream, or when not loadable: `i_req_r` is all 0 and `rr_ptr` holds.
- Completion: on `i_cpl_v`, `cnt[i_cpl_sid]` decrements.
- Simultaneous grant and completion on the same stream: the count is unchanged.
- Completion when the count is 0: the count stays 0 and `o_err` is set; only reset clears `o_err`.
- `i_cpl_sid >= nstrms`: the completion is ignored and `o_err` is set.
- Output hold: a pending `o_req_v` holds `sid` and `ea` stable until accepted; no retraction.

## Timing
- Reset values:
  - `o_req_v=0`, `o_req_sid=0`, `o_req_ea=0`, `o_err=0`
  - `i_req_r=0`, `i_cpl_r=0` while reset is asserted
  - all `cnt=0`, `rr_ptr=0`
- Reset asserted mid-operation: all state clears immediately (asynchronous); any in-flight output request is dropped.
- Latency: input handshake at cycle N gives `o_req_v=1` at cycle N+1.
- Throughput: one grant per cycle while `o_req_r=1`.
- Downstream stall: with `o_req_r=0` and the output full, no grants are made and `cnt` changes only by completions.
- Credit update: a counter change from a grant or completion at edge N affects eligibility at cycle N+1. A completion can re-enable a stream that is at `max_out` one cycle after `i_cpl_v`.

## Configuration
- `STREAM_REQ_ARB_CREDIT_EN` defined:
  - credit counters, `max_out` limiting, completion port and `o_err` as above.
- Not defined:
  - eligibility is `i_req_v[s]` only (pure round-robin); no counters are instantiated.
  - `i_cpl_r` ties to 1, completions are ignored, and `o_err` ties to 0.

## Test plan
- Test parameters: `nstrms=4`, `max_out=2`, `o_req_r=1` unless stated.
- Reset:
  - Hold `reset=0` and drive all `i_req_v=1` -> `o_req_v=0` and `i_req_r=4'b0000`.
  - Release reset -> first grant to sid 0, `o_req_v=1` on the next cycle.
- Fairness: all four streams requesting continuously with completions returned each cycle -> `o_req_sid` sequence 0,1,2,3,0,1 and `i_req_r` one-hot each cycle.
- Credit limit:
  - Only stream 2 requests, no completions -> exactly two grants, then `i_req_r[2]=0` indefinitely.
  - One completion with sid 2 -> third grant one cycle later.
- Backpressure:
  - Hold `o_req_r=0` for 5 cycles with stream 1 requesting `ea=0x1000` -> `o_req_v=1`, sid 1, `ea 0x1000` stable throughout, one grant only.
- Simultaneous events: grant to stream 3 in the same cycle as a completion for sid 3 with `cnt[3]=1` -> `cnt[3]` stays 1.
- Error:
  - Completion for sid 1 with `cnt[1]=0` -> `o_err=1` next cycle, sticks, and `cnt[1]` stays 0.
  - Without the macro, the same stimulus -> `o_err=0`.
